// File: rtl/netwalk_tcam_programmer.sv
// Control-plane programmer for one TCAM unit: add/delete/flush commands in,
// program/delete strobes out, one status response per command.
module netwalk_tcam_programmer #(
    parameter int DPL_MATCH_FIELD_WIDTH = 356,
    parameter int TCAM_ADDR_WIDTH       = 6,
    parameter int PROG_CYCLES           = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_op,
    input  logic [TCAM_ADDR_WIDTH-1:0]       cmd_addr,
    input  logic [DPL_MATCH_FIELD_WIDTH-1:0] cmd_data,
    input  logic [DPL_MATCH_FIELD_WIDTH-1:0] cmd_mask,
    output logic                             rsp_valid,
    output logic [1:0]                       rsp_status,
    output logic [TCAM_ADDR_WIDTH-1:0]       rsp_addr,
    output logic [DPL_MATCH_FIELD_WIDTH-1:0] tcam_program_data,
    output logic [DPL_MATCH_FIELD_WIDTH-1:0] tcam_program_mask,
    output logic [TCAM_ADDR_WIDTH-1:0]       tcam_program_addr,
    output logic                             tcam_program_enable,
    output logic                             tcam_delete_enable,
    output logic                             tcam_unit_sel,
    output logic [TCAM_ADDR_WIDTH:0]         entry_count,
    output logic                             tcam_full
);
    localparam int DEPTH = 2 ** TCAM_ADDR_WIDTH;
    localparam int CW    = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
    localparam logic [CW-1:0]              CNT_LAST  = CW'(PROG_CYCLES - 1);
    localparam logic [TCAM_ADDR_WIDTH:0]   DEPTH_CNT = (TCAM_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [TCAM_ADDR_WIDTH-1:0] ADDR_LAST = '1;

    localparam logic [1:0] OP_ADD_AUTO = 2'b00;
    localparam logic [1:0] OP_ADD_AT   = 2'b01;
    localparam logic [1:0] OP_DELETE   = 2'b10;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_REPLACED  = 2'b01;
    localparam logic [1:0] ST_FULL      = 2'b10;
    localparam logic [1:0] ST_NOT_FOUND = 2'b11;

    typedef enum logic [1:0] {IDLE, PROG, FLUSH, RESP} state_t;

    state_t                           state_reg;
    logic                             cmd_ready_reg;
    logic [CW-1:0]                    cnt_reg;
    logic                             del_reg;
    logic                             replaced_reg;
    logic [DEPTH-1:0]                 bitmap_reg;
    logic [TCAM_ADDR_WIDTH:0]         count_reg;
    logic [TCAM_ADDR_WIDTH-1:0]       prog_addr_reg;
    logic [DPL_MATCH_FIELD_WIDTH-1:0] prog_data_reg;
    logic [DPL_MATCH_FIELD_WIDTH-1:0] prog_mask_reg;
    logic                             prog_en_reg;
    logic                             del_en_reg;
    logic                             rsp_valid_reg;
    logic [1:0]                       rsp_status_reg;
    logic [TCAM_ADDR_WIDTH-1:0]       rsp_addr_reg;

    logic [TCAM_ADDR_WIDTH-1:0]       free_idx;
    logic [TCAM_ADDR_WIDTH-1:0]       flush_addr_next;

    // Descending scan so the last hit wins: lowest clear bit of the bitmap.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!bitmap_reg[i]) free_idx = TCAM_ADDR_WIDTH'(i);
        end
    end

    assign flush_addr_next = prog_addr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cmd_ready_reg  <= 1'b0;
            cnt_reg        <= '0;
            del_reg        <= 1'b0;
            replaced_reg   <= 1'b0;
            bitmap_reg     <= '0;
            count_reg      <= '0;
            prog_addr_reg  <= '0;
            prog_data_reg  <= '0;
            prog_mask_reg  <= '0;
            prog_en_reg    <= 1'b0;
            del_en_reg     <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_status_reg <= ST_OK;
            rsp_addr_reg   <= '0;
        end else begin
            rsp_valid_reg  <= 1'b0;
            rsp_status_reg <= ST_OK;
            rsp_addr_reg   <= '0;
            case (state_reg)
                IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_valid && cmd_ready_reg) begin
                        cmd_ready_reg <= 1'b0;
                        cnt_reg       <= '0;
                        del_reg       <= 1'b0;
                        replaced_reg  <= 1'b0;
                        case (cmd_op)
                            OP_ADD_AUTO: begin
                                if (count_reg == DEPTH_CNT) begin
                                    state_reg      <= RESP;
                                    rsp_valid_reg  <= 1'b1;
                                    rsp_status_reg <= ST_FULL;
                                end else begin
                                    state_reg     <= PROG;
                                    prog_addr_reg <= free_idx;
                                    prog_data_reg <= cmd_data;
                                    prog_mask_reg <= cmd_mask;
                                    prog_en_reg   <= 1'b1;
                                end
                            end
                            OP_ADD_AT: begin
                                state_reg     <= PROG;
                                prog_addr_reg <= cmd_addr;
                                prog_data_reg <= cmd_data;
                                prog_mask_reg <= cmd_mask;
                                prog_en_reg   <= 1'b1;
                                replaced_reg  <= bitmap_reg[cmd_addr];
                            end
                            OP_DELETE: begin
                                if (!bitmap_reg[cmd_addr]) begin
                                    state_reg      <= RESP;
                                    rsp_valid_reg  <= 1'b1;
                                    rsp_status_reg <= ST_NOT_FOUND;
                                    rsp_addr_reg   <= cmd_addr;
                                end else begin
                                    state_reg     <= PROG;
                                    prog_addr_reg <= cmd_addr;
                                    prog_data_reg <= '0;
                                    prog_mask_reg <= '0;
                                    prog_en_reg   <= 1'b1;
                                    del_en_reg    <= 1'b1;
                                    del_reg       <= 1'b1;
                                end
                            end
                            default: begin
                                // Flush slot 0 starts immediately; strobes only for valid entries.
                                state_reg     <= FLUSH;
                                prog_addr_reg <= '0;
                                prog_data_reg <= '0;
                                prog_mask_reg <= '0;
                                prog_en_reg   <= bitmap_reg[0];
                                del_en_reg    <= bitmap_reg[0];
                            end
                        endcase
                    end
                end
                PROG: begin
                    if (cnt_reg == CNT_LAST) begin
                        state_reg      <= RESP;
                        prog_en_reg    <= 1'b0;
                        del_en_reg     <= 1'b0;
                        prog_addr_reg  <= '0;
                        prog_data_reg  <= '0;
                        prog_mask_reg  <= '0;
                        rsp_valid_reg  <= 1'b1;
                        rsp_addr_reg   <= prog_addr_reg;
                        rsp_status_reg <= replaced_reg ? ST_REPLACED : ST_OK;
                        if (del_reg) begin
                            bitmap_reg[prog_addr_reg] <= 1'b0;
                            if (count_reg != '0) count_reg <= count_reg - 1'b1;
                        end else begin
                            bitmap_reg[prog_addr_reg] <= 1'b1;
                            if (!replaced_reg && count_reg != DEPTH_CNT)
                                count_reg <= count_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        if (prog_addr_reg == ADDR_LAST) begin
                            state_reg     <= RESP;
                            prog_en_reg   <= 1'b0;
                            del_en_reg    <= 1'b0;
                            prog_addr_reg <= '0;
                            bitmap_reg    <= '0;
                            count_reg     <= '0;
                            rsp_valid_reg <= 1'b1;
                        end else begin
                            prog_addr_reg <= flush_addr_next;
                            prog_en_reg   <= bitmap_reg[flush_addr_next];
                            del_en_reg    <= bitmap_reg[flush_addr_next];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    cmd_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready           = cmd_ready_reg;
    assign rsp_valid           = rsp_valid_reg;
    assign rsp_status          = rsp_status_reg;
    assign rsp_addr            = rsp_addr_reg;
    assign tcam_program_data   = prog_data_reg;
    assign tcam_program_mask   = prog_mask_reg;
    assign tcam_program_addr   = prog_addr_reg;
    assign tcam_program_enable = prog_en_reg;
    assign tcam_delete_enable  = del_en_reg;
    assign tcam_unit_sel       = prog_en_reg | del_en_reg;
    assign entry_count         = count_reg;
    assign tcam_full           = (count_reg == DEPTH_CNT);

endmodule
